// File: rtl/pi_share_sched_pkg.sv
// Shared types and constants for the time-shared PI scheduler.
package pi_share_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ERR  = 2'd1,
      S_MAC  = 2'd2,
      S_WB   = 2'd3
   } state_e;

   localparam int FRAC_DEFAULT = 8;
   // Headroom above W+GW so Kp*diff + Ki*err never wraps.
   localparam int MAC_GUARD    = 2;

endpackage

// File: rtl/pi_share_sched_mac.sv
// Registered PI multiply-accumulate: (kp*diff + ki*err) >>> FRAC, floor rounding.
module pi_share_sched_mac
   import pi_share_sched_pkg::*;
#(
   parameter  int W    = 32,
   parameter  int GW   = 16,
   parameter  int FRAC = FRAC_DEFAULT,
   localparam int PW   = W + GW + MAC_GUARD
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_i,
   input  logic [GW-1:0]        kp_i,
   input  logic [GW-1:0]        ki_i,
   input  logic signed [W-1:0]  err_i,
   input  logic signed [W-1:0]  diff_i,
   output logic signed [PW-1:0] delta_o
);

   logic signed [PW-1:0] kp_s, ki_s, err_s, diff_s, acc_s;
   logic signed [PW-1:0] delta_d, delta_q;

   always_comb begin
      kp_s    = {{(PW-GW){1'b0}}, kp_i};
      ki_s    = {{(PW-GW){1'b0}}, ki_i};
      err_s   = {{(PW-W){err_i[W-1]}}, err_i};
      diff_s  = {{(PW-W){diff_i[W-1]}}, diff_i};
      acc_s   = kp_s * diff_s + ki_s * err_s;
      delta_d = acc_s >>> FRAC;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         delta_q <= '0;
      end else if (load_i) begin
         delta_q <= delta_d;
      end
   end

   assign delta_o = delta_q;

endmodule

// File: rtl/pi_share_sched.sv
// Round-robin time-sharing of one incremental PI engine across N_CH channels,
// with per-channel capture buffers, state bank and clamped integrators.
module pi_share_sched
   import pi_share_sched_pkg::*;
#(
   parameter  int                N_CH  = 2,
   parameter  int                W     = 32,
   parameter  int                GW    = 16,
   parameter  int                FRAC  = FRAC_DEFAULT,
   parameter  logic signed [W-1:0] U_MAX = {1'b0, {(W-1){1'b1}}},
   parameter  logic signed [W-1:0] U_MIN = {1'b1, {(W-1){1'b0}}},
   localparam int                CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_CH-1:0]      en_i,
   input  logic [N_CH-1:0]      clr_i,
   input  logic [N_CH-1:0]      s_valid,
   input  logic [N_CH*W-1:0]    s_data,
   input  logic [N_CH*W-1:0]    ref_i,
   input  logic [N_CH*GW-1:0]   kp_i,
   input  logic [N_CH*GW-1:0]   ki_i,
   output logic                 y_valid,
   output logic [CW-1:0]        y_ch,
   output logic [W-1:0]         y_data,
   output logic [N_CH*W-1:0]    uk_o,
   output logic [N_CH-1:0]      sat_o,
   output logic [N_CH-1:0]      ovf_o,
   output logic                 busy_o
);

   localparam int unsigned NC = N_CH;
   localparam int          PW = W + GW + MAC_GUARD;
   localparam logic signed [PW:0] UMAX_W = {{(PW+1-W){U_MAX[W-1]}}, U_MAX};
   localparam logic signed [PW:0] UMIN_W = {{(PW+1-W){U_MIN[W-1]}}, U_MIN};

   function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] v);
      if (v[W] != v[W-1]) begin
         return v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
      return v[W-1:0];
   endfunction

   state_e               state_q, state_d;
   logic [N_CH-1:0]      pend_q, ovf_q, sat_q;
   logic signed [W-1:0]  pbuf_q [N_CH];
   logic signed [W-1:0]  u_q    [N_CH];
   logic signed [W-1:0]  ep_q   [N_CH];
   logic [CW-1:0]        ptr_q, ptr_d, g_q;
   logic signed [W-1:0]  x_q, err_q, diff_q;
   logic [GW-1:0]        kp_q, ki_q;
   logic                 kill_q, kill_d;
   logic                 y_valid_q;
   logic [CW-1:0]        y_ch_q;
   logic signed [W-1:0]  y_data_q;

   logic signed [W-1:0]  ref_a [N_CH];
   logic signed [W-1:0]  sd_a  [N_CH];
   logic [GW-1:0]        kp_a  [N_CH];
   logic [GW-1:0]        ki_a  [N_CH];
   logic [N_CH-1:0]      req;
   logic                 gnt_any, grant_now, kill_eff, wb_fire, clamped;
   logic [CW-1:0]        gnt_idx;
   int unsigned          rr_idx;
   logic signed [W-1:0]  err_c, diff_c, u_new;
   logic signed [PW-1:0] delta;
   logic signed [PW:0]   sum_w;

   always_comb begin
      uk_o = '0;
      for (int unsigned c = 0; c < NC; c++) begin
         ref_a[c]          = ref_i[c*W +: W];
         sd_a[c]           = s_data[c*W +: W];
         kp_a[c]           = kp_i[c*GW +: GW];
         ki_a[c]           = ki_i[c*GW +: GW];
         uk_o[c*W +: W]    = u_q[c];
      end
   end

   // A channel being cleared this cycle is never granted.
   always_comb begin
      req     = pend_q & en_i & ~clr_i;
      gnt_any = 1'b0;
      gnt_idx = '0;
      rr_idx  = 0;
      for (int unsigned k = 0; k < NC; k++) begin
         rr_idx = (k + 32'(ptr_q)) % NC;
         if (!gnt_any && req[rr_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = CW'(rr_idx);
         end
      end
      grant_now = gnt_any && (state_q == S_IDLE || state_q == S_WB);
      ptr_d     = CW'((32'(gnt_idx) + 32'd1) % NC);
   end

   always_comb begin
      err_c    = sat_w({ref_a[g_q][W-1], ref_a[g_q]} - {x_q[W-1], x_q});
      diff_c   = sat_w({err_c[W-1], err_c} - {ep_q[g_q][W-1], ep_q[g_q]});
      sum_w    = {{(PW+1-W){u_q[g_q][W-1]}}, u_q[g_q]} + {delta[PW-1], delta};
      clamped  = 1'b1;
      if (sum_w > UMAX_W) begin
         u_new = U_MAX;
      end else if (sum_w < UMIN_W) begin
         u_new = U_MIN;
      end else begin
         u_new   = sum_w[W-1:0];
         clamped = 1'b0;
      end
      kill_eff = kill_q | clr_i[g_q];
      wb_fire  = (state_q == S_WB) && !kill_eff;
   end

   always_comb begin
      state_d = state_q;
      kill_d  = kill_q;
      case (state_q)
         S_IDLE: begin
            kill_d = 1'b0;
            if (grant_now) state_d = S_ERR;
         end
         S_ERR: begin
            state_d = S_MAC;
            kill_d  = kill_eff;
         end
         S_MAC: begin
            state_d = S_WB;
            kill_d  = kill_eff;
         end
         S_WB: begin
            kill_d  = 1'b0;
            state_d = grant_now ? S_ERR : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         kill_q    <= 1'b0;
         ptr_q     <= '0;
         g_q       <= '0;
         x_q       <= '0;
         err_q     <= '0;
         diff_q    <= '0;
         kp_q      <= '0;
         ki_q      <= '0;
         y_valid_q <= 1'b0;
         y_ch_q    <= '0;
         y_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         kill_q    <= kill_d;
         y_valid_q <= wb_fire;
         if (grant_now) begin
            g_q   <= gnt_idx;
            x_q   <= pbuf_q[gnt_idx];
            ptr_q <= ptr_d;
         end
         if (state_q == S_ERR) begin
            err_q  <= err_c;
            diff_q <= diff_c;
            kp_q   <= kp_a[g_q];
            ki_q   <= ki_a[g_q];
         end
         if (wb_fire) begin
            y_ch_q   <= g_q;
            y_data_q <= u_new;
         end
      end
   end

   // Capture coinciding with a grant of the same channel refills the buffer without overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         ovf_q  <= '0;
         sat_q  <= '0;
         for (int unsigned c = 0; c < NC; c++) begin
            pbuf_q[c] <= '0;
            u_q[c]    <= '0;
            ep_q[c]   <= '0;
         end
      end else begin
         for (int unsigned c = 0; c < NC; c++) begin
            if (clr_i[c]) begin
               pend_q[c] <= 1'b0;
               ovf_q[c]  <= 1'b0;
               sat_q[c]  <= 1'b0;
               u_q[c]    <= '0;
               ep_q[c]   <= '0;
            end else begin
               if (!en_i[c]) begin
                  pend_q[c] <= 1'b0;
               end else if (s_valid[c]) begin
                  pbuf_q[c] <= sd_a[c];
                  pend_q[c] <= 1'b1;
                  if (pend_q[c] && !(grant_now && gnt_idx == CW'(c))) ovf_q[c] <= 1'b1;
               end else if (grant_now && gnt_idx == CW'(c)) begin
                  pend_q[c] <= 1'b0;
               end
               if (wb_fire && g_q == CW'(c)) begin
                  u_q[c]   <= u_new;
                  ep_q[c]  <= err_q;
                  sat_q[c] <= clamped;
               end
            end
         end
      end
   end

   pi_share_sched_mac #(
      .W    (W),
      .GW   (GW),
      .FRAC (FRAC)
   ) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (state_q == S_MAC),
      .kp_i    (kp_q),
      .ki_i    (ki_q),
      .err_i   (err_q),
      .diff_i  (diff_q),
      .delta_o (delta)
   );

   assign y_valid = y_valid_q;
   assign y_ch    = y_ch_q;
   assign y_data  = y_data_q;
   assign sat_o   = sat_q;
   assign ovf_o   = ovf_q;
   assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_pi_share_sched.sv
// Scoreboard bench: directed samples push hand-computed results; monitors pop on y_valid.
module tb_pi_share_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  en, clr_a, clr_b, sv_a, sv_b;
   logic [63:0] sd, refv;
   logic [31:0] kp, ki;

   logic        yv_a, yv_b, busy_a, busy_b;
   logic [0:0]  ych_a, ych_b;
   logic [31:0] yd_a, yd_b;
   logic [63:0] uk_a, uk_b;
   logic [1:0]  sat_a, sat_b, ovf_a, ovf_b;

   typedef struct { int ch; int data; } exp_t;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   pi_share_sched dut_a (
      .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr_a), .s_valid(sv_a), .s_data(sd),
      .ref_i(refv), .kp_i(kp), .ki_i(ki), .y_valid(yv_a), .y_ch(ych_a), .y_data(yd_a),
      .uk_o(uk_a), .sat_o(sat_a), .ovf_o(ovf_a), .busy_o(busy_a)
   );

   pi_share_sched #(.U_MAX(32'sd250)) dut_b (
      .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr_b), .s_valid(sv_b), .s_data(sd),
      .ref_i(refv), .kp_i(kp), .ki_i(ki), .y_valid(yv_b), .y_ch(ych_b), .y_data(yd_b),
      .uk_o(uk_b), .sat_o(sat_b), .ovf_o(ovf_b), .busy_o(busy_b)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && yv_a) begin
         if (qa.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL a_unexpected: got result ch=%0d data=%0d, expected none", ych_a, $signed(yd_a));
         end else begin
            ea = qa.pop_front();
            check("a_y_ch", longint'(ych_a), ea.ch);
            check("a_y_data", $signed(yd_a), ea.data);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && yv_b) begin
         if (qb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL b_unexpected: got result ch=%0d data=%0d, expected none", ych_b, $signed(yd_b));
         end else begin
            eb = qb.pop_front();
            check("b_y_ch", longint'(ych_b), eb.ch);
            check("b_y_data", $signed(yd_b), eb.data);
         end
      end
   end

   task automatic push_a(input int ch, input int data);
      exp_t e;
      e.ch = ch;
      e.data = data;
      qa.push_back(e);
   endtask

   task automatic push_b(input int ch, input int data);
      exp_t e;
      e.ch = ch;
      e.data = data;
      qb.push_back(e);
   endtask

   task automatic pulse_a(input logic [1:0] m, input int x0, input int x1);
      sv_a = m;
      sd   = {x1, x0};
      @(negedge clk);
      sv_a = '0;
   endtask

   task automatic pulse_b(input logic [1:0] m, input int x0, input int x1);
      sv_b = m;
      sd   = {x1, x0};
      @(negedge clk);
      sv_b = '0;
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         #1;
         if (qa.size() == 0 && qb.size() == 0 && !busy_a && !busy_b) done = 1'b1;
      end
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s_timeout: got pending a=%0d b=%0d, expected 0", name, qa.size(), qb.size());
         qa.delete();
         qb.delete();
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      en    = 2'b11;
      clr_a = '0;
      clr_b = '0;
      sv_a  = '0;
      sv_b  = '0;
      sd    = '0;
      refv  = {-32'sd1000, 32'sd100};
      kp    = {16'd512, 16'd256};
      ki    = {16'd128, 16'd256};
      repeat (3) @(negedge clk);
      check("rst_y_valid", yv_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_uk", uk_a, 0);
      check("rst_flags", {sat_a, ovf_a}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Test 1: ch0 ref=100, gains 1.0; u = 200 then 300, result 4 edges after strobe
      push_a(0, 200);
      pulse_a(2'b01, 0, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t1_latency_a", yv_a, (k == 3));
      end
      wait_idle("t1a");
      push_a(0, 300);
      pulse_a(2'b01, 0, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t1_latency_b", yv_a, (k == 3));
      end
      wait_idle("t1b");
      check("t1_uk0", $signed(uk_a[31:0]), 300);
      check("t1_sat0", sat_a[0], 0);

      // Test 3 on clamped instance: 200, 250 (clamped), then err=-100, diff=-200 -> -50
      push_b(0, 200);
      pulse_b(2'b01, 0, 0);
      wait_idle("t3a");
      check("t3_sat_first", sat_b[0], 0);
      push_b(0, 250);
      pulse_b(2'b01, 0, 0);
      wait_idle("t3b");
      check("t3_sat_clamped", sat_b[0], 1);
      push_b(0, -50);
      pulse_b(2'b01, 200, 0);
      wait_idle("t3c");
      check("t3_sat_release", sat_b[0], 0);
      check("t3_uk0", $signed(uk_b[31:0]), -50);

      // Test 2: last grant ch0, so pair goes ch1 first; ch1 restrobe makes ch0 win next
      push_a(1, -13);
      push_a(0, 400);
      push_a(1, 4);
      pulse_a(2'b11, 0, -995);
      @(negedge clk);
      pulse_a(2'b10, 0, -1003);
      wait_idle("t2");
      check("t2_ovf", ovf_a, 0);

      // Test 4: two ch1 samples while ch0 in flight -> overflow, second sample used
      push_a(0, 500);
      push_a(1, -2);
      pulse_a(2'b01, 0, 0);
      @(negedge clk);
      pulse_a(2'b10, 0, -2000);
      pulse_a(2'b10, 0, -1000);
      check("t4_ovf_set", ovf_a, 2);
      wait_idle("t4");
      check("t4_uk1", $signed(uk_a[63:32]), -2);
      clr_a = 2'b10;
      @(negedge clk);
      clr_a = '0;
      check("t4_ovf_clr", ovf_a, 0);
      check("t4_uk1_clr", $signed(uk_a[63:32]), 0);

      // Sample arriving on the grant edge stays pending without overflow
      push_a(1, 25);
      push_a(1, -20);
      pulse_a(2'b10, 0, -1010);
      pulse_a(2'b10, 0, -990);
      wait_idle("t4b");
      check("t4b_ovf", ovf_a, 0);

      // Test 5: clear ch0 during MAC kills its result
      pulse_a(2'b01, 0, 0);
      @(negedge clk);
      @(negedge clk);
      clr_a = 2'b01;
      @(negedge clk);
      clr_a = '0;
      check("t5_uk0_clr", $signed(uk_a[31:0]), 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t5_no_result", yv_a, 0);
      end
      clr_a = 2'b01;
      sv_a  = 2'b01;
      sd    = '0;
      @(negedge clk);
      clr_a = '0;
      sv_a  = '0;
      @(negedge clk);
      @(negedge clk);
      check("t5_clr_wins", busy_a, 0);
      push_a(0, 200);
      pulse_a(2'b01, 0, 0);
      wait_idle("t5");
      check("t5_uk0", $signed(uk_a[31:0]), 200);

      // Test 6: reset during WB clears outputs at once; restart from u=0
      pulse_a(2'b01, 0, 0);
      repeat (3) @(negedge clk);
      check("t6_busy_wb", busy_a, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_y_valid", yv_a, 0);
      check("t6_y_data", yd_a, 0);
      check("t6_uk", uk_a, 0);
      check("t6_busy", busy_a, 0);
      check("t6_flags", {sat_a, ovf_a}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push_a(0, 200);
      pulse_a(2'b01, 0, 0);
      wait_idle("t6");
      check("t6_uk0", $signed(uk_a[31:0]), 200);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
